// File: rtl/reg_reader_pkg.sv
// reg_reader shared types and helpers.
// Optional hazard statistics are enabled with REG_READER_STATS_EN.
package reg_reader_pkg;

  localparam int NREG_DEF = 8;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 4;

  localparam logic [AW_DEF-1:0] RNONE = 4'hF;

  typedef logic [AW_DEF-1:0] reg_idx_t;

  // Any index at or above nreg means "no register".
  function automatic logic is_reg(
    input logic [31:0] idx,
    input int          nreg
  );
    return idx < 32'(nreg);
  endfunction

endpackage

// File: rtl/reg_bypass_mux.sv
// Operand select for one source: writeback bypass over register file.
// M writeback wins over E, matching the register file write order.
module reg_bypass_mux
  import reg_reader_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic [AW-1:0]      src,
  input  logic [NREG*DW-1:0] rf_flat,
  input  logic [AW-1:0]      dstE,
  input  logic [DW-1:0]      valE,
  input  logic [AW-1:0]      dstM,
  input  logic [DW-1:0]      valM,
  output logic [DW-1:0]      value,
  output logic               wb_hit
);

  logic          valid;
  logic          hit_e;
  logic          hit_m;
  logic [DW-1:0] rf_val;

  assign valid  = is_reg(32'(src), NREG);
  assign hit_e  = valid && (dstE == src);
  assign hit_m  = valid && (dstM == src);
  assign wb_hit = hit_e || hit_m;

  always_comb begin
    rf_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src == AW'(i)) begin
        rf_val = rf_flat[i*DW +: DW];
      end
    end
  end

  always_comb begin
    value = '0;
    if (!valid) begin
      value = '0;
    end else if (hit_m) begin
      value = valM;
    end else if (hit_e) begin
      value = valE;
    end else begin
      value = rf_val;
    end
  end

endmodule

// File: rtl/reg_reader.sv
// Register read stage: bypass, scoreboard hazards, 1-cycle output reg.
// Define REG_READER_STATS_EN to enable the hazard-stall counter.
module reg_reader
  import reg_reader_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREG*DW-1:0] rf_flat,
  input  logic [AW-1:0]      dstE,
  input  logic [DW-1:0]      valE,
  input  logic [AW-1:0]      dstM,
  input  logic [DW-1:0]      valM,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      srcA,
  input  logic [AW-1:0]      srcB,
  input  logic [AW-1:0]      allocE,
  input  logic [AW-1:0]      allocM,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      valA,
  output logic [DW-1:0]      valB,
  output logic [NREG-1:0]    pending,
  output logic [15:0]        stall_cnt
);

  function automatic logic [NREG-1:0] dec(
    input logic [AW-1:0] idx
  );
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      oh[i] = (idx == AW'(i));
    end
    return oh;
  endfunction

  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            hit_a;
  logic            hit_b;
  logic [NREG-1:0] wb;
  logic [NREG-1:0] live;
  logic [NREG-1:0] dst_oh;
  logic [NREG-1:0] set;
  logic [NREG-1:0] pending_nx;
  logic            raw_a;
  logic            raw_b;
  logic            waw;
  logic            hazard_any;
  logic            accept;

  reg_bypass_mux #(
    .NREG(NREG), .DW(DW), .AW(AW)
  ) u_mux_a (
    .src    (srcA),
    .rf_flat(rf_flat),
    .dstE   (dstE),
    .valE   (valE),
    .dstM   (dstM),
    .valM   (valM),
    .value  (sel_a),
    .wb_hit (hit_a)
  );

  reg_bypass_mux #(
    .NREG(NREG), .DW(DW), .AW(AW)
  ) u_mux_b (
    .src    (srcB),
    .rf_flat(rf_flat),
    .dstE   (dstE),
    .valE   (valE),
    .dstM   (dstM),
    .valM   (valM),
    .value  (sel_b),
    .wb_hit (hit_b)
  );

  assign wb   = dec(dstE) | dec(dstM);
  assign live = pending & ~wb;

  // A source committing this edge is bypassed, so it is not a hazard.
  assign raw_a = (|(dec(srcA) & pending)) && !hit_a;
  assign raw_b = (|(dec(srcB) & pending)) && !hit_b;

  assign dst_oh     = dec(allocE) | dec(allocM);
  assign waw        = |(dst_oh & live);
  assign hazard_any = raw_a || raw_b || waw;

  assign in_ready = !flush && !hazard_any
                 && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // New allocation wins over a same-cycle clear of the same register.
  assign set        = accept ? dst_oh : '0;
  assign pending_nx = flush ? '0 : (live | set);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      valA      <= '0;
      valB      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      valA      <= sel_a;
      valB      <= sel_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef REG_READER_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard_any
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
